// File: rtl/prog_chain_loader_if.sv
// Configuration-word valid/ready handshake between the bitstream source
// (master) and prog_chain_loader (slave).
interface prog_chain_loader_if #(
  parameter int unsigned WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] cfg_data;
  logic                  cfg_valid;
  logic                  cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/prog_chain_loader.sv
// Serialises configuration words onto the fabric programming chain, CHAIN_LEN bits per load.
// Optional readback of the chain tail is built when PROG_LOADER_READBACK_EN is defined.
module prog_chain_loader #(
  parameter int unsigned CHAIN_LEN  = 64,
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  prog_clk,
  input  logic                  prog_rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  prog_chain_loader_if.slave    cfg,
  output logic                  chain_in,
  output logic                  chain_en,
  input  logic                  chain_out,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid
);
  localparam int unsigned NWORDS = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned IDX_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int unsigned WA_W   = $clog2(NWORDS + 1);
  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_WIDTH - 1);
  localparam logic [WA_W-1:0]  NWORDS_C = WA_W'(NWORDS);

  typedef enum logic [1:0] {IDLE, FILL, SHIFT, DONE} state_e;

  state_e                state_q;
  logic [WORD_WIDTH-1:0] shreg_q;
  logic [WORD_WIDTH-1:0] hold_q;
  logic                  hold_full_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [WA_W-1:0]       words_q;
  logic                  chain_in_q;
  logic                  chain_en_q;
  logic                  done_q;

  logic handshake;
  logic last_bit;
  logic word_end;

  always_comb begin
    cfg.cfg_ready = (state_q == FILL) ||
                    ((state_q == SHIFT) && !hold_full_q && (words_q < NWORDS_C));
    handshake     = cfg.cfg_valid && cfg.cfg_ready;
    last_bit      = (cnt_q + CNT_W'(1)) == LEN_C;
    // Bits of a partial last word above the chain length end the word early.
    word_end      = (idx_q == IDX_LAST) || last_bit;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      words_q     <= '0;
      chain_in_q  <= 1'b0;
      chain_en_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          chain_in_q <= 1'b0;
          chain_en_q <= 1'b0;
          if (start) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            words_q     <= '0;
            idx_q       <= '0;
            hold_full_q <= 1'b0;
          end
        end
        FILL: begin
          chain_en_q <= 1'b0;
          if (handshake) begin
            shreg_q <= cfg.cfg_data;
            idx_q   <= '0;
            words_q <= words_q + WA_W'(1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == LEN_C) begin
            chain_in_q <= 1'b0;
            chain_en_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            chain_in_q <= shreg_q[0];
            chain_en_q <= 1'b1;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (word_end) begin
              idx_q <= '0;
              // A word arriving exactly at an empty-hold boundary bypasses the hold register.
              if (hold_full_q) begin
                shreg_q     <= hold_q;
                hold_full_q <= 1'b0;
              end else if (handshake) begin
                shreg_q <= cfg.cfg_data;
              end else if (!last_bit) begin
                state_q <= FILL;
              end
            end else begin
              shreg_q <= shreg_q >> 1;
              idx_q   <= idx_q + IDX_W'(1);
            end
            if (handshake) begin
              words_q <= words_q + WA_W'(1);
              if (!(word_end && !hold_full_q)) begin
                hold_q      <= cfg.cfg_data;
                hold_full_q <= 1'b1;
              end
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign chain_in = chain_in_q;
  assign chain_en = chain_en_q;

`ifdef PROG_LOADER_READBACK_EN
  logic [WORD_WIDTH-1:0] rb_acc_q;
  logic [WORD_WIDTH-1:0] rb_data_q;
  logic [IDX_W-1:0]      rb_idx_q;
  logic                  rb_valid_q;
  logic [WORD_WIDTH-1:0] rb_word;
  logic                  finishing;

  // The final sample coincides with the edge that raises done, so a partial word flushes there.
  always_comb begin
    finishing         = (state_q == SHIFT) && (cnt_q == LEN_C);
    rb_word           = rb_acc_q;
    rb_word[rb_idx_q] = chain_out;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      rb_acc_q   <= '0;
      rb_data_q  <= '0;
      rb_idx_q   <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (chain_en_q) begin
        if ((rb_idx_q == IDX_LAST) || finishing) begin
          rb_data_q  <= rb_word;
          rb_valid_q <= 1'b1;
          rb_acc_q   <= '0;
          rb_idx_q   <= '0;
        end else begin
          rb_acc_q <= rb_word;
          rb_idx_q <= rb_idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_chain_out;
  assign unused_chain_out = chain_out;
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif
endmodule

// File: tb/tb_prog_chain_loader.sv
// Bench for prog_chain_loader: two instances (16/8 and 10/4) driven with random words and gaps,
// checked against a bit-level model of the load and a behavioural model of the fabric chain.
`timescale 1ns/1ps
module tb_prog_chain_loader;
  localparam int unsigned L0 = 16, W0 = 8, L1 = 10, W1 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start0, start1, busy0, busy1, done0, done1;
  logic cin0, cin1, cen0, cen1, cout0, cout1, rbv0, rbv1;
  logic [W0-1:0] rbd0;
  logic [W1-1:0] rbd1;

  prog_chain_loader_if #(.WORD_WIDTH(W0)) bus0();
  prog_chain_loader_if #(.WORD_WIDTH(W1)) bus1();

  prog_chain_loader #(.CHAIN_LEN(L0), .WORD_WIDTH(W0)) dut0 (
    .prog_clk(clk), .prog_rst(rst), .start(start0), .busy(busy0), .done(done0),
    .cfg(bus0), .chain_in(cin0), .chain_en(cen0), .chain_out(cout0),
    .rb_data(rbd0), .rb_valid(rbv0));

  prog_chain_loader #(.CHAIN_LEN(L1), .WORD_WIDTH(W1)) dut1 (
    .prog_clk(clk), .prog_rst(rst), .start(start1), .busy(busy1), .done(done1),
    .cfg(bus1), .chain_in(cin1), .chain_en(cen1), .chain_out(cout1),
    .rb_data(rbd1), .rb_valid(rbv1));

  // Fabric chain model: index 0 is the tail flop feeding chain_out.
  logic [L0-1:0] ch0;
  logic [L1-1:0] ch1;
  always @(posedge clk) begin
    if (cen0) ch0 <= {cin0, ch0[L0-1:1]};
    if (cen1) ch1 <= {cin1, ch1[L1-1:1]};
  end
  assign cout0 = ch0[0];
  assign cout1 = ch1[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  int en_cnt[2], done_cnt[2], first_en[2], done_cyc[2], stall[2], stall_rdy[2];
  int rb_cnt[2], rb_bad[2], rb_at_done[2];
  logic [31:0] got_vec[2], rb_vec[2];
  logic [7:0] wq[$];
  logic [31:0] exp_vec, exp_rb;
  int hs_cnt, t0;

  task automatic mon(input int s, input logic en, input logic in, input logic dn,
                     input logic bz, input logic rdy, input logic rbv,
                     input logic [31:0] rbd, input int ww);
    if (dn) begin done_cnt[s]++; done_cyc[s] = cyc; end
    if (en) begin
      if (en_cnt[s] < 32) got_vec[s][en_cnt[s]] = in;
      if (first_en[s] < 0) first_en[s] = cyc;
      en_cnt[s]++;
    end else if (bz && first_en[s] >= 0 && done_cnt[s] == 0) begin
      stall[s]++;
      if (rdy) stall_rdy[s]++;
    end
    if (rbv) begin
      if (rb_cnt[s] < 4) rb_vec[s] = rb_vec[s] | (rbd << (rb_cnt[s] * ww));
      rb_cnt[s]++;
      if (dn) rb_at_done[s]++;
    end else if (rbd != 0) rb_bad[s]++;
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, cen0, cin0, done0, busy0, bus0.cfg_ready, rbv0, 32'(rbd0), int'(W0));
    mon(1, cen1, cin1, done1, busy1, bus1.cfg_ready, rbv1, 32'(rbd1), int'(W1));
  end

  task automatic clear_mon();
    for (int s = 0; s < 2; s++) begin
      en_cnt[s] = 0; done_cnt[s] = 0; first_en[s] = -1; done_cyc[s] = -1;
      stall[s] = 0; stall_rdy[s] = 0; rb_cnt[s] = 0; rb_bad[s] = 0; rb_at_done[s] = 0;
      got_vec[s] = '0; rb_vec[s] = '0;
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [7:0] d);
    if (s == 0) begin bus0.cfg_valid = v; bus0.cfg_data = d; end
    else begin bus1.cfg_valid = v; bus1.cfg_data = d[W1-1:0]; end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start0 = v; else start1 = v;
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? bus0.cfg_ready : bus1.cfg_ready;
  endfunction

  task automatic fill_words(input int s);
    int nw;
    nw = (s == 0) ? int'((L0 + W0 - 1) / W0) : int'((L1 + W1 - 1) / W1);
    wq.delete();
    for (int k = 0; k < nw; k++) wq.push_back(8'($urandom));
  endtask

  // One load: the expected stream is the words' bits LSB-first, truncated to the chain length,
  // and the expected readback is the chain contents before the load.
  task automatic run_load(input int s, input int gapmax, input int gap1, input bit hold_v, input bit poke);
    int L, W, n, i, gap, budget;
    L = (s == 0) ? int'(L0) : int'(L1);
    W = (s == 0) ? int'(W0) : int'(W1);
    exp_vec = '0;
    for (int b = 0; b < L; b++) exp_vec[b] = wq[b / W][b % W];
    exp_rb = (s == 0) ? 32'(ch0) : 32'(ch1);
    @(negedge clk);
    clear_mon(); hs_cnt = 0;
    set_start(s, 1'b1); t0 = cyc;
    i = 0; gap = 0; budget = 0; n = wq.size();
    while (done_cnt[s] == 0 && budget < 2000) begin
      @(negedge clk); budget++;
      set_start(s, poke && en_cnt[s] == 3);
      if (i < n) begin
        if (gap > 0) begin drive(s, 1'b0, 8'h00); gap--; end
        else begin
          drive(s, 1'b1, wq[i]);
          if (rdy(s)) begin
            i++; hs_cnt++;
            gap = (i == 1 && gap1 > 0) ? gap1 : ((gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
          end
        end
      end else begin
        drive(s, hold_v, 8'($urandom));
        if (hold_v && rdy(s)) hs_cnt++;
      end
    end
    drive(s, 1'b0, 8'h00); set_start(s, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
    n_checks++; if (bus0.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus0.cfg_ready); end
    n_checks++; if (cin0 !== 1'b0) begin n_fail++; $display("FAIL reset_chain_in: got %b want 0", cin0); end
    n_checks++; if (cen0 !== 1'b0) begin n_fail++; $display("FAIL reset_chain_en: got %b want 0", cen0); end
    n_checks++; if (rbd0 !== '0) begin n_fail++; $display("FAIL reset_rb_data: got %h want 0", rbd0); end
    n_checks++; if (rbv0 !== 1'b0) begin n_fail++; $display("FAIL reset_rb_valid: got %b want 0", rbv0); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h3C);
    run_load(0, 0, 0, 1'b1, 1'b0);
    n_checks++; if (got_vec[0] !== 32'h3CA5) begin n_fail++; $display("FAIL basic_bits: got %h want 3ca5", got_vec[0]); end
    n_checks++; if (en_cnt[0] != 16 || stall[0] != 0) begin n_fail++; $display("FAIL basic_en: got %0d shifts %0d stalls want 16/0", en_cnt[0], stall[0]); end
    n_checks++; if (done_cnt[0] != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt[0]); end
    n_checks++; if (first_en[0] != t0 + 3) begin n_fail++; $display("FAIL basic_first_en: got %0d want %0d", first_en[0], t0 + 3); end
    n_checks++; if (done_cyc[0] != t0 + 19) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc[0], t0 + 19); end
    n_checks++; if (ch0 !== 16'h3CA5) begin n_fail++; $display("FAIL basic_chain: got %h want 3ca5", ch0); end
  endtask

  task automatic test_partial_word();
    wq.delete(); wq.push_back(8'h0F); wq.push_back(8'h00); wq.push_back(8'h0E);
    run_load(1, 0, 0, 1'b1, 1'b0);
    n_checks++; if (got_vec[1] !== 32'h20F) begin n_fail++; $display("FAIL partial_bits: got %h want 20f", got_vec[1]); end
    n_checks++; if (en_cnt[1] != 10) begin n_fail++; $display("FAIL partial_en_count: got %0d want 10", en_cnt[1]); end
    n_checks++; if (done_cnt[1] != 1) begin n_fail++; $display("FAIL partial_done: got %0d want 1", done_cnt[1]); end
    n_checks++; if (hs_cnt != 3) begin n_fail++; $display("FAIL partial_words: got %0d want 3", hs_cnt); end
  endtask

  task automatic test_starvation();
    wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h3C);
    run_load(0, 0, 12, 1'b0, 1'b0);
    n_checks++; if (got_vec[0] !== 32'h3CA5) begin n_fail++; $display("FAIL starve_bits: got %h want 3ca5", got_vec[0]); end
    n_checks++; if (en_cnt[0] != 16) begin n_fail++; $display("FAIL starve_en_count: got %0d want 16", en_cnt[0]); end
    n_checks++; if (stall[0] == 0 || stall_rdy[0] == 0) begin n_fail++; $display("FAIL starve_gap: got %0d stalls %0d ready want both >0", stall[0], stall_rdy[0]); end
    n_checks++; if (done_cyc[0] != t0 + 19 + stall[0]) begin n_fail++; $display("FAIL starve_done_cycle: got %0d want %0d", done_cyc[0], t0 + 19 + stall[0]); end
    n_checks++; if (done_cnt[0] != 1) begin n_fail++; $display("FAIL starve_done: got %0d want 1", done_cnt[0]); end
  endtask

  task automatic test_readback();
    wq.delete(); wq.push_back(8'h34); wq.push_back(8'h12);
    run_load(0, 0, 0, 1'b0, 1'b0);
    n_checks++; if (ch0 !== 16'h1234) begin n_fail++; $display("FAIL rb_preload_chain: got %h want 1234", ch0); end
    fill_words(0);
    run_load(0, 2, 0, 1'b0, 1'b0);
`ifdef PROG_LOADER_READBACK_EN
    n_checks++; if (rb_vec[0] !== 32'h1234) begin n_fail++; $display("FAIL rb_words: got %h want 1234", rb_vec[0]); end
    n_checks++; if (rb_cnt[0] != 2 || rb_at_done[0] != 1) begin n_fail++; $display("FAIL rb_strobes: got %0d (%0d at done) want 2 (1)", rb_cnt[0], rb_at_done[0]); end
`else
    n_checks++; if (rb_cnt[0] + rb_bad[0] != 0) begin n_fail++; $display("FAIL rb_disabled: got %0d strobes %0d nonzero want 0", rb_cnt[0], rb_bad[0]); end
`endif
  endtask

  task automatic test_reset_mid_load();
    int budget = 0;
    @(negedge clk); clear_mon();
    start0 = 1'b1; drive(0, 1'b1, 8'hC3);
    @(negedge clk); start0 = 1'b0;
    while (en_cnt[0] < 5 && budget < 100) begin @(negedge clk); budget++; end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++; if (cen0 !== 1'b0 || busy0 !== 1'b0 || bus0.cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: got en=%b busy=%b ready=%b want 0/0/0", cen0, busy0, bus0.cfg_ready); end
    drive(0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    n_checks++; if (done_cnt[0] != 0 || en_cnt[0] != 5) begin n_fail++; $display("FAIL abort_quiet: got %0d done %0d shifts want 0/5", done_cnt[0], en_cnt[0]); end
    fill_words(0);
    run_load(0, 3, 0, 1'b0, 1'b0);
    n_checks++; if (got_vec[0] !== exp_vec || en_cnt[0] != 16) begin n_fail++; $display("FAIL abort_reload: got %h/%0d want %h/16", got_vec[0], en_cnt[0], exp_vec); end
    n_checks++; if (done_cnt[0] != 1) begin n_fail++; $display("FAIL abort_reload_done: got %0d want 1", done_cnt[0]); end
  endtask

  task automatic test_start_while_busy();
    fill_words(0);
    run_load(0, 0, 0, 1'b1, 1'b1);
    n_checks++; if (en_cnt[0] != 16 || got_vec[0] !== exp_vec) begin n_fail++; $display("FAIL busy_start_bits: got %h/%0d want %h/16", got_vec[0], en_cnt[0], exp_vec); end
    n_checks++; if (hs_cnt != 2) begin n_fail++; $display("FAIL busy_extra_words: got %0d want 2", hs_cnt); end
    n_checks++; if (done_cnt[0] != 1 || busy0 !== 1'b0) begin n_fail++; $display("FAIL busy_restart: got %0d done busy=%b want 1/0", done_cnt[0], busy0); end
  endtask

  task automatic test_random();
    logic [31:0] chv;
    for (int it = 0; it < 8; it++) begin
      int s = it % 2;
      fill_words(s);
      run_load(s, 10, 0, 1'($urandom), 1'b0);
      chv = (s == 0) ? 32'(ch0) : 32'(ch1);
      n_checks++; if (got_vec[s] !== exp_vec) begin n_fail++; $display("FAIL rand%0d_bits: got %h want %h", it, got_vec[s], exp_vec); end
      n_checks++; if (en_cnt[s] != ((s == 0) ? 16 : 10) || done_cnt[s] != 1) begin n_fail++; $display("FAIL rand%0d_counts: got %0d shifts %0d done", it, en_cnt[s], done_cnt[s]); end
      n_checks++; if (chv !== exp_vec) begin n_fail++; $display("FAIL rand%0d_chain: got %h want %h", it, chv, exp_vec); end
`ifdef PROG_LOADER_READBACK_EN
      n_checks++; if (rb_vec[s] !== exp_rb || rb_at_done[s] != 1) begin n_fail++; $display("FAIL rand%0d_rb: got %h (%0d at done) want %h (1)", it, rb_vec[s], rb_at_done[s], exp_rb); end
`else
      n_checks++; if (rb_cnt[s] + rb_bad[s] != 0) begin n_fail++; $display("FAIL rand%0d_rb_off: got %0d want 0", it, rb_cnt[s] + rb_bad[s]); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    drive(0, 1'b0, 8'h00); drive(1, 1'b0, 8'h00);
    ch0 = 16'($urandom); ch1 = 10'($urandom);
    clear_mon();
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_partial_word();
    test_starvation();
    test_readback();
    test_reset_mid_load();
    test_start_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_chain_loader.md
# prog_chain_loader

Drives the serial configuration chain of the fabric (switch boxes, connection blocks, LUTs) from a word-wide bitstream source. Accepts configuration words over a valid/ready handshake, serializes them onto the chain's shift input with shift-enable, and counts exactly CHAIN_LEN bits. Optionally captures the bits shifted out of the far end of the chain as readback words. Sits between the bitstream source (host/ROM interface) and the head of the fabric's programming chain.

## Interface
- CHAIN_LEN, 64: total configuration bits in the chain; must be ≥ 1.
- WORD_WIDTH, 8: bits per input and readback word; must be ≥ 1.

- prog_clk  in  1  clock; the same clock that drives the chain's shift flops.
- prog_rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when the load completes.
- cfg_data  in  WORD_WIDTH  configuration word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  loader accepts a word this cycle.
- chain_in  out  1  serial data to the chain head.
- chain_en  out  1  chain shift enable; the chain shifts on each prog_clk edge where it is high.
- chain_out  in  1  serial data from the chain tail.
- rb_data  out  WORD_WIDTH  readback word (READBACK build only; otherwise tied to 0).
- rb_valid  out  1  one-cycle strobe for rb_data; there is no backpressure.

## Operation
- States: IDLE, FILL, SHIFT, DONE.
- IDLE -> FILL on start. In IDLE, cfg_ready = 0.
- FILL: cfg_ready = 1. A handshake (valid & ready) loads the shift register, sets the bit-in-word index to 0, and moves to SHIFT.
- SHIFT: each cycle, chain_in = shreg[0] and chain_en = 1. After the cycle, shreg shifts right and the bit counter increments.
- A holding register gives gap-free streaming. cfg_ready = 1 in SHIFT while the holding register is empty and words remain (words_accepted < ceil(CHAIN_LEN/WORD_WIDTH)).
- Word boundary with the holding register full: transfer it into shreg with no gap.
- Word boundary with the holding register empty (starved): chain_en = 0 and the state returns to FILL. The chain holds its contents and no bits are lost.
- Bit counter width is $clog2(CHAIN_LEN+1). When the counter reaches CHAIN_LEN, go to DONE.
- Partial last word: cfg_data bits above (CHAIN_LEN mod WORD_WIDTH) are ignored and never shifted.
- DONE: done = 1 for one cycle, then IDLE. Excess cfg_valid is never accepted.
- start while busy is ignored.
- Bit placement: the first bit shifted ends in the chain's last flop (the one nearest chain_out); bit CHAIN_LEN-1 ends in the head flop.
- Reset values: state IDLE, busy 0, done 0, cfg_ready 0, chain_in 0, chain_en 0, rb_data 0, rb_valid 0, all counters 0.
- Reset mid-load aborts on that edge: chain_en drops next cycle, no done pulse, and chain contents are undefined.

## Timing
- chain_in and chain_en are registered and change together. The chain samples them on the following prog_clk edge.
- Handshake accepted at edge N (from FILL) -> chain_en = 1 with bit 0 in cycle N+1.
- Uninterrupted load: chain_en is high for exactly CHAIN_LEN consecutive cycles. done is high in the cycle after the last chain_en cycle.
- Start at cycle 0, first word valid at cycle 1, no starvation: done at cycle CHAIN_LEN+3.
- Readback sampling: chain_out is sampled on every edge where chain_en = 1, i.e. the tail value before that shift. Sample k is therefore old chain bit k, counted from the tail.

## Configuration
- PROG_LOADER_READBACK_EN defined:
  - Sampled chain_out bits pack LSB-first into rb_data.
  - rb_valid pulses the cycle after each WORD_WIDTH-th sample.
  - A final partial word, zero-padded in its upper bits, is emitted coincident with done.
- PROG_LOADER_READBACK_EN undefined:
  - No readback logic is built; rb_data = 0 and rb_valid = 0 permanently.
  - chain_out is unused.

## Test plan
- CHAIN_LEN=16, WORD_WIDTH=8, words 0xA5 then 0x3C, cfg_valid held high -> chain_en high 16 consecutive cycles; chain_in sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; done exactly once.
- CHAIN_LEN=10, WORD_WIDTH=4, words 0xF, 0x0, 0xE -> 10 shifts; bits 3:2 of the last word are never driven; third-word bits shifted are 0,1.
- Starvation: second word withheld for 5 cycles -> chain_en low for those cycles; cfg_ready high; output bit sequence identical to the unstalled case.
- Readback (macro on): chain preloaded with 0x1234 (CHAIN_LEN=16, WORD_WIDTH=8), reload with any data -> rb_data 0x34 then 0x12, each with a one-cycle rb_valid.
- prog_rst asserted after 5 shifts -> next cycle chain_en=0, busy=0, cfg_ready=0; no done. A new start then performs a full CHAIN_LEN-bit load.
- start pulsed during SHIFT, and cfg_valid held high after the final word -> no restart and no extra word accepted; exactly CHAIN_LEN shifts.
